// File: rtl/efuse_pgm_ctrl_pkg.sv
// eFuse program sequencer shared types: FSM state, default timings
// and the remaining-ones helper used by the bit scanner.
package efuse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SETUP,
        SCAN,
        AEN_H,
        AEN_L,
        HOLD,
        DONE
    } pgm_state_t;

    localparam int DEF_TSETUP = 2;
    localparam int DEF_TPGM   = 10;
    localparam int DEF_TGAP   = 3;

    // Widest word the helper accepts; callers zero-extend.
    localparam int MAXW = 256;

    // True when any bit at position idx or above is set.
    function automatic logic ones_from(
        input logic [MAXW-1:0] d,
        input int              idx
    );
        return (d >> idx) != '0;
    endfunction

endpackage

// File: rtl/efuse_pgm_ctrl_if.sv
// Write request channel between register block and program sequencer.
// master: sel/data/start/abort out; slave: done/err/busy/prog_cnt out.
interface efuse_pgm_ctrl_if #(
    parameter int NW   = 64,
    parameter int WSEL = 4
);
    localparam int SW = $clog2(WSEL);
    localparam int PW = $clog2(NW + 1);

    logic [SW-1:0] write_sel;
    logic [NW-1:0] write_data;
    logic          write_start;
    logic          write_abort;
    logic          write_done;
    logic          write_err;
    logic          busy_write;
    logic [PW-1:0] prog_cnt;

    modport master (
        output write_sel, write_data, write_start, write_abort,
        input  write_done, write_err, busy_write, prog_cnt
    );

    modport slave (
        input  write_sel, write_data, write_start, write_abort,
        output write_done, write_err, busy_write, prog_cnt
    );
endinterface

// File: rtl/efuse_pgm_ctrl_timer.sv
// Loadable down-counter for fuse phase timing.
// Ports: load/load_val restart the count; expired is high at zero.
module efuse_timer #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/efuse_pgm_ctrl.sv
// eFuse program sequencer: blows each set bit of one word in turn.
// Ports: clk/rst_n, cfg_* timings, lock_mask, wr (request channel), efuse_* macro pins.
module efuse_pgm_ctrl
    import efuse_pkg::*;
#(
    parameter int NW    = 64,
    parameter int NBITS = 256,
    parameter int WSEL  = NBITS / NW,
    parameter int AW    = $clog2(NBITS),
    parameter int CW    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CW-1:0]   cfg_tsetup,
    input  logic [CW-1:0]   cfg_tpgm,
    input  logic [CW-1:0]   cfg_tgap,
    input  logic [WSEL-1:0] lock_mask,
    efuse_pgm_ctrl_if.slave wr,
    output logic            efuse_pgmen_o,
    output logic            efuse_rden_o,
    output logic            efuse_aen_o,
    output logic [AW-1:0]   efuse_addr_o
);
    localparam int SW = $clog2(WSEL);
    localparam int IW = $clog2(NW);
    localparam int PW = $clog2(NW + 1);

    pgm_state_t    state_q, state_d;
    logic [NW-1:0] data_q;
    logic [SW-1:0] sel_q;
    logic [CW-1:0] ts_q, tp_q, tg_q;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic          err_q, abort_q;
    logic          accept, pulse, set_err, set_abort;
    logic          tmr_load, tmr_exp;
    logic [CW-1:0] tmr_val;
    logic          more_here, more_next;

    assign accept    = (state_q == IDLE) && wr.write_start;
    assign more_here = ones_from(MAXW'(data_q), int'(idx_q));
    assign more_next = ones_from(MAXW'(data_q), int'(idx_q) + 1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pulse     = 1'b0;
        set_err   = 1'b0;
        set_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (wr.write_start) state_d = CHECK;
            end
            CHECK: begin
                if (lock_mask[sel_q]) begin
                    state_d = DONE;
                    set_err = 1'b1;
                end else if (data_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (wr.write_abort) begin
                    state_d = HOLD;
                    set_err = 1'b1;
                end else if (tmr_exp) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (wr.write_abort) begin
                    state_d = HOLD;
                    set_err = 1'b1;
                end else if (!more_here) begin
                    state_d = HOLD;
                end else if (data_q[idx_q]) begin
                    state_d = AEN_H;
                    pulse   = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            AEN_H: begin
                // Abort is only noted here; the pulse always runs full width.
                if (wr.write_abort) begin
                    set_abort = 1'b1;
                    set_err   = 1'b1;
                end
                if (tmr_exp) state_d = AEN_L;
            end
            AEN_L: begin
                if (wr.write_abort) begin
                    set_abort = 1'b1;
                    set_err   = 1'b1;
                end
                if (tmr_exp) begin
                    if (abort_q || wr.write_abort || !more_next) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (tmr_exp) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timer restarts on every entry into a timed phase.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            SETUP, HOLD: tmr_val = ts_q - CW'(1);
            AEN_H:       tmr_val = tp_q - CW'(1);
            AEN_L:       tmr_val = tg_q - CW'(1);
            default:     tmr_load = 1'b0;
        endcase
    end

    efuse_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            ts_q    <= '0;
            tp_q    <= '0;
            tg_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // Tracks the scan index so the address leads aen by a cycle.
            addr_q  <= (state_d == IDLE) ? '0 :
                       AW'(int'(sel_q) * NW + int'(idx_d));
            if (accept) begin
                data_q  <= wr.write_data;
                sel_q   <= wr.write_sel;
                ts_q    <= (cfg_tsetup == '0) ? CW'(1) : cfg_tsetup;
                tp_q    <= (cfg_tpgm == '0) ? CW'(1) : cfg_tpgm;
                tg_q    <= (cfg_tgap == '0) ? CW'(1) : cfg_tgap;
                cnt_q   <= '0;
                err_q   <= 1'b0;
                abort_q <= 1'b0;
            end else begin
                if (pulse)     cnt_q   <= cnt_q + PW'(1);
                if (set_err)   err_q   <= 1'b1;
                if (set_abort) abort_q <= 1'b1;
            end
        end
    end

    assign efuse_pgmen_o  = (state_q == SETUP) || (state_q == SCAN) ||
                            (state_q == AEN_H) || (state_q == AEN_L) ||
                            (state_q == HOLD);
    assign efuse_aen_o    = (state_q == AEN_H);
    assign efuse_rden_o   = 1'b0;
    assign efuse_addr_o   = addr_q;
    assign wr.write_done  = (state_q == DONE);
    assign wr.busy_write  = (state_q != IDLE);
    assign wr.write_err   = err_q;
    assign wr.prog_cnt    = cnt_q;
endmodule

// File: tb/tb_efuse_pgm_ctrl.sv
// Bench for efuse_pgm_ctrl: per-cycle pin trace from a phase-list model.
// Directed cases first, then randomized words, timings, locks and aborts.
module tb_efuse_pgm_ctrl;
    import efuse_pkg::*;

    localparam int NW    = 64;
    localparam int NBITS = 256;
    localparam int WSEL  = 4;
    localparam int AW    = 8;
    localparam int CW    = 10;
    localparam int SW    = 2;

    localparam int P_CHECK = 0;
    localparam int P_SETUP = 1;
    localparam int P_SCAN  = 2;
    localparam int P_AENH  = 3;
    localparam int P_AENL  = 4;
    localparam int P_HOLD  = 5;
    localparam int P_DONE  = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CW-1:0]   cfg_tsetup = '0;
    logic [CW-1:0]   cfg_tpgm = '0;
    logic [CW-1:0]   cfg_tgap = '0;
    logic [WSEL-1:0] lock_mask = '0;
    logic            pgmen, rden, aen;
    logic [AW-1:0]   addr;

    int   vectors = 0;
    int   miscompares = 0;
    int   ph[$];
    int   ad[$];
    int   exp_cnt;
    logic exp_err;
    int   busy_seen;

    always #5 clk = ~clk;

    efuse_pgm_ctrl_if #(.NW(NW), .WSEL(WSEL)) wr ();

    efuse_pgm_ctrl #(
        .NW(NW), .NBITS(NBITS), .WSEL(WSEL), .AW(AW), .CW(CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_tsetup    (cfg_tsetup),
        .cfg_tpgm      (cfg_tpgm),
        .cfg_tgap      (cfg_tgap),
        .lock_mask     (lock_mask),
        .wr            (wr),
        .efuse_pgmen_o (pgmen),
        .efuse_rden_o  (rden),
        .efuse_aen_o   (aen),
        .efuse_addr_o  (addr)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_pins();
        return 64'({wr.busy_write, pgmen, aen, wr.write_done, rden,
                    aen ? addr : AW'(0)});
    endfunction

    function automatic logic [63:0] obs_all();
        return 64'({wr.busy_write, pgmen, aen, wr.write_done, rden,
                    addr, wr.prog_cnt, wr.write_err});
    endfunction

    function automatic logic [63:0] exp_pins(input int p, input int a);
        logic pg;
        pg = (p >= P_SETUP) && (p <= P_HOLD);
        return 64'({1'b1, pg, p == P_AENH, p == P_DONE, 1'b0, AW'(a)});
    endfunction

    function automatic int clamp1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic push(input int p, input int a);
        ph.push_back(p);
        ad.push_back(a);
    endtask

    // Phase list straight from the sequencing rules: check, setup,
    // then per set bit the scan walk, pulse and gap, then hold, done.
    task automatic build(input int sel, input logic [63:0] data,
                         input int ts, input int tp, input int tg,
                         input bit locked);
        int cur;
        cur = 0;
        ph.delete();
        ad.delete();
        exp_cnt = 0;
        exp_err = locked;
        push(P_CHECK, 0);
        if (locked || data == '0) begin
            push(P_DONE, 0);
            return;
        end
        repeat (ts) push(P_SETUP, 0);
        for (int b = 0; b < NW; b++) begin
            if (data[b]) begin
                repeat (b - cur + 1) push(P_SCAN, 0);
                repeat (tp) push(P_AENH, sel * NW + b);
                repeat (tg) push(P_AENL, 0);
                cur = b + 1;
                exp_cnt++;
            end
        end
        repeat (ts) push(P_HOLD, 0);
        push(P_DONE, 0);
    endtask

    // Abort held from cycle a: first abortable cycle ends the request,
    // except that a pulse already started finishes with its gap.
    task automatic apply_abort(input int a, input int ts);
        int t;
        int cut;
        t = -1;
        for (int i = a; i < ph.size(); i++) begin
            if (ph[i] >= P_SETUP && ph[i] <= P_AENL) begin
                t = i;
                break;
            end
        end
        if (t < 0) return;
        cut = t + 1;
        if (ph[t] == P_AENH || ph[t] == P_AENL) begin
            while (cut < ph.size() &&
                   (ph[cut] == P_AENH || ph[cut] == P_AENL)) cut++;
        end
        while (ph.size() > cut) begin
            void'(ph.pop_back());
            void'(ad.pop_back());
        end
        repeat (ts) push(P_HOLD, 0);
        push(P_DONE, 0);
        exp_err = 1'b1;
        exp_cnt = 0;
        for (int i = 1; i < ph.size(); i++) begin
            if (ph[i] == P_AENH && ph[i-1] != P_AENH) exp_cnt++;
        end
    endtask

    task automatic run_req(input int sel, input logic [63:0] data,
                           input int rts, input int rtp, input int rtg,
                           input int abort_at, input int spur_at,
                           input int rst_at);
        int ts;
        ts = clamp1(rts);
        build(sel, data, ts, clamp1(rtp), clamp1(rtg), lock_mask[sel]);
        if (abort_at == -2) abort_at = $urandom_range(0, ph.size() - 1);
        if (abort_at >= 0) apply_abort(abort_at, ts);
        cfg_tsetup = CW'(rts);
        cfg_tpgm = CW'(rtp);
        cfg_tgap = CW'(rtg);
        wr.write_sel = SW'(sel);
        wr.write_data = data;
        wr.write_start = 1'b1;
        @(negedge clk);
        wr.write_start = 1'b0;
        cfg_tsetup = CW'($urandom);
        cfg_tpgm = CW'($urandom);
        cfg_tgap = CW'($urandom);
        busy_seen = 0;
        for (int i = 0; i < ph.size(); i++) begin
            if (i > 0) @(negedge clk);
            wr.write_start = 1'b0;
            check($sformatf("cyc%0d", i), obs_pins(), exp_pins(ph[i], ad[i]));
            if (wr.busy_write) busy_seen++;
            if (i == abort_at) wr.write_abort = 1'b1;
            if (i == spur_at) begin
                wr.write_start = 1'b1;
                wr.write_data = ~data;
                wr.write_sel = SW'(sel + 1);
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_mid", obs_all(), 64'h0);
                wr.write_abort = 1'b0;
                wr.write_start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        wr.write_abort = 1'b0;
        wr.write_start = 1'b0;
        check("idle_pins", obs_pins(), 64'h0);
        check("prog_cnt", 64'(wr.prog_cnt), 64'(exp_cnt));
        check("write_err", 64'(wr.write_err), 64'(exp_err));
    endtask

    initial begin
        logic [63:0] d;
        int ab;
        wr.write_sel = '0;
        wr.write_data = '0;
        wr.write_start = 1'b0;
        wr.write_abort = 1'b0;
        #1;
        check("reset_state", obs_all(), 64'h0);
        repeat (3) @(negedge clk);
        check("reset_hold", obs_all(), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", obs_all(), 64'h0);

        run_req(1, 64'h1, DEF_TSETUP, DEF_TPGM, DEF_TGAP, -1, -1, -1);
        check("t1_busy", 64'(busy_seen), 64'd20);

        run_req(0, 64'h8000_0000_0000_0001, 2, 10, 3, -1, -1, -1);
        check("t2_cnt", 64'(wr.prog_cnt), 64'd2);

        run_req(3, 64'h0, 2, 10, 3, -1, -1, -1);
        check("t3_zero_busy", 64'(busy_seen), 64'd2);
        lock_mask = 4'b0100;
        run_req(2, 64'hDEAD_BEEF_0000_1234, 2, 10, 3, -1, -1, -1);
        check("t3_lock_busy", 64'(busy_seen), 64'd2);
        check("t3_lock_err", 64'(wr.write_err), 64'd1);
        lock_mask = '0;

        run_req(0, 64'hF, 2, 10, 3, 22, -1, -1);
        check("t4_cnt", 64'(wr.prog_cnt), 64'd2);
        check("t4_err", 64'(wr.write_err), 64'd1);

        run_req(1, 64'h0000_0000_0000_0A05, 0, 0, 0, -1, 3, -1);
        check("t5_cnt", 64'(wr.prog_cnt), 64'd4);

        run_req(1, 64'h1, 2, 10, 3, -1, -1, 6);
        run_req(2, 64'h11, 2, 10, 3, -1, -1, -1);

        repeat (30) begin
            lock_mask = ($urandom_range(0, 3) == 0) ? WSEL'($urandom) : '0;
            d = {$urandom, $urandom} & {$urandom, $urandom} &
                {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) d = '0;
            ab = ($urandom_range(0, 2) == 0) ? -2 : -1;
            run_req($urandom_range(0, 3), d, $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 4), ab, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
